// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous character RAM between VGA reads, a clear-screen sweep and CPU accesses.
// VGA always wins the port; the sweep outranks the CPU, which is acknowledged one cycle after its grant.
module vram_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4800,
  parameter logic [DATA_W-1:0] CLR_VAL = 8'h20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vga_rdn,
  input  logic [12:0]       vga_addr,
  output logic [DATA_W-1:0] vga_q,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [12:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [12:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACK} state_t;
  localparam logic [12:0] LAST = 13'(DEPTH - 1);
  state_t            r_state;
  logic [12:0]       r_clr_cnt;
  logic              r_pend, r_ack, r_err, r_rd, r_busy, r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              w_clr_req, w_oor, w_cpu_go, w_clr_gnt, w_cpu_gnt;

  assign w_clr_req = r_pend | clr_start;
  assign w_oor     = cpu_addr > LAST;
  // rstn gates the grants so nothing but a VGA read reaches the RAM during reset
  assign w_cpu_go  = rstn & (r_state == S_IDLE) & ~w_clr_req & cpu_req & vga_rdn;
  assign w_cpu_gnt = w_cpu_go & ~w_oor;
  assign w_clr_gnt = rstn & (r_state == S_CLEAR) & vga_rdn;

  always_comb begin
    ram_en    = ~vga_rdn | w_clr_gnt | w_cpu_gnt;
    ram_we    = vga_rdn & (w_clr_gnt | (w_cpu_gnt & cpu_we));
    ram_addr  = ~vga_rdn ? vga_addr : w_clr_gnt ? r_clr_cnt : cpu_addr;
    ram_wdata = w_clr_gnt ? CLR_VAL : cpu_wdata;
  end

  assign vga_q     = ram_q;
  assign cpu_ack   = r_ack;
  assign cpu_err   = r_err;
  assign cpu_rdata = r_rdata;
  assign clr_busy  = r_busy;
  assign clr_done  = r_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
      r_pend    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rd      <= 1'b0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_clr_req) begin
            r_state <= S_CLEAR;
            r_pend  <= 1'b0;
            r_busy  <= 1'b1;
          end else if (w_cpu_go) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_err   <= w_oor;
            r_rd    <= ~cpu_we & ~w_oor;
          end
        end
        S_CLEAR: begin
          if (vga_rdn) begin
            r_clr_cnt <= (r_clr_cnt == LAST) ? '0 : r_clr_cnt + 13'd1;
            if (r_clr_cnt == LAST) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_ACK: begin
          if (r_rd) r_rdata <= ram_q;
          r_state <= S_IDLE;
          r_err   <= 1'b0;
          r_rd    <= 1'b0;
          if (clr_start) begin
            r_pend <= 1'b1;
            r_busy <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized checks of vram_arbiter against a reference memory image and the arbitration rules.
module tb_vram_arbiter;
  localparam int DEPTH = 4800;
  logic        clk = 0;
  logic        rstn, vga_rdn, cpu_req, cpu_we, cpu_ack, cpu_err, clr_start, clr_busy, clr_done;
  logic        ram_en, ram_we;
  logic [12:0] vga_addr, cpu_addr, ram_addr;
  logic [7:0]  vga_q, cpu_wdata, cpu_rdata, ram_wdata, ram_q;
  logic [7:0]  mem [8192];
  logic [7:0]  ref_mem [DEPTH];
  int checks = 0, failures = 0;

  vram_arbiter #(.DATA_W(8), .DEPTH(DEPTH), .CLR_VAL(8'h20)) dut (
    .clk(clk), .rstn(rstn), .vga_rdn(vga_rdn), .vga_addr(vga_addr), .vga_q(vga_q),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_xfer(input logic we, input logic [12:0] a, input logic [7:0] d, input int vga_pct,
                          output int lat, output logic err, output int bad_en);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = -1; err = 0; bad_en = 0;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      vga_rdn = ($urandom_range(99) < vga_pct) ? 1'b0 : 1'b1;
      vga_addr = 13'($urandom_range(DEPTH - 1));
      @(negedge clk);
      if (ram_en && vga_rdn && a >= 13'(DEPTH)) bad_en++;
      if (cpu_ack) begin lat = c; err = cpu_err; cpu_req = 0; end
      tick;
    end
    cpu_req = 0; vga_rdn = 1;
  endtask

  task automatic test_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'd5; cpu_wdata = 8'hAA; vga_rdn = 1;
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
    checks++; if ({cpu_ack, cpu_err, clr_busy, clr_done} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {cpu_ack, cpu_err, clr_busy, clr_done}); end
    checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", cpu_rdata); end
    vga_rdn = 0; vga_addr = 13'd7;
    #1;
    checks++; if ({ram_en, ram_we} !== 2'b10 || ram_addr !== 13'd7) begin failures++; $display("FAIL reset_vga_read got en/we=%b addr=%0d exp 10/7", {ram_en, ram_we}, ram_addr); end
    vga_rdn = 1; cpu_req = 0;
    tick;
    rstn = 1;
    tick;
  endtask

  task automatic test_write_read;
    int lat, bad_en;
    logic err;
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'd100; cpu_wdata = 8'h41; vga_rdn = 1;
    @(negedge clk);
    checks++; if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 13'd100 || ram_wdata !== 8'h41) begin failures++; $display("FAIL wr_grant got en/we=%b addr=%0d data=%h exp 11/100/41", {ram_en, ram_we}, ram_addr, ram_wdata); end
    tick;
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_err} !== 2'b10) begin failures++; $display("FAIL wr_ack got ack/err=%b exp 10", {cpu_ack, cpu_err}); end
    cpu_req = 0;
    tick;
    ref_mem[100] = 8'h41;
    cpu_xfer(1'b0, 13'd100, 8'h00, 0, lat, err, bad_en);
    checks++; if (lat < 0 || err !== 1'b0 || cpu_rdata !== 8'h41) begin failures++; $display("FAIL rd_back got lat=%0d err=%b rdata=%h exp ack/0/41", lat, err, cpu_rdata); end
  endtask

  task automatic test_clear;
    int writes = 0, dones = 0, bad = 0, bad_busy = 0, extra = 0;
    logic [12:0] exp_a = 0;
    vga_rdn = 1; clr_start = 1;
    tick;
    clr_start = 0;
    for (int c = 0; c < 30000 && dones == 0; c++) begin
      vga_rdn = 1'($urandom_range(1));
      vga_addr = 13'($urandom_range(DEPTH - 1));
      clr_start = (c == 100);
      @(negedge clk);
      if (ram_en && ram_we) begin
        if (ram_addr !== exp_a || ram_wdata !== 8'h20) bad++;
        exp_a++; writes++;
      end
      if (clr_done) dones++; else if (!clr_busy) bad_busy++;
      tick;
    end
    clr_start = 0; vga_rdn = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (clr_done || (ram_en && ram_we) || clr_busy) extra++;
      tick;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h20;
    checks++; if (writes != DEPTH) begin failures++; $display("FAIL clr_writes got=%0d exp=%0d", writes, DEPTH); end
    checks++; if (bad != 0) begin failures++; $display("FAIL clr_order got=%0d bad writes exp=0", bad); end
    checks++; if (dones != 1) begin failures++; $display("FAIL clr_done_count got=%0d exp=1", dones); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL clr_busy_during got=%0d low cycles exp=0", bad_busy); end
    checks++; if (extra != 0) begin failures++; $display("FAIL clr_after got=%0d stray events exp=0", extra); end
  endtask

  task automatic test_random;
    int lat, bad_en;
    logic err, we;
    logic [12:0] a;
    logic [7:0] d, prev;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(1)); a = 13'($urandom_range(63)); d = 8'($urandom); prev = cpu_rdata;
      cpu_xfer(we, a, d, 50, lat, err, bad_en);
      checks++; if (lat < 0 || err !== 1'b0) begin failures++; $display("FAIL rand_ack[%0d] got lat=%0d err=%b exp ack/0", i, lat, err); end
      if (we) begin
        ref_mem[a] = d;
        checks++; if (cpu_rdata !== prev) begin failures++; $display("FAIL rand_wr_hold[%0d] got=%h exp=%h", i, cpu_rdata, prev); end
      end else begin
        checks++; if (cpu_rdata !== ref_mem[a]) begin failures++; $display("FAIL rand_rd[%0d] addr=%0d got=%h exp=%h", i, a, cpu_rdata, ref_mem[a]); end
      end
      vga_rdn = 0; vga_addr = 13'($urandom_range(63));
      tick;
      vga_rdn = 1;
      checks++; if (vga_q !== ref_mem[vga_addr]) begin failures++; $display("FAIL rand_vga[%0d] addr=%0d got=%h exp=%h", i, vga_addr, vga_q, ref_mem[vga_addr]); end
    end
  endtask

  task automatic test_vga_stall;
    int bad = 0, lat = -1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'd200; cpu_wdata = 8'h5A;
    for (int c = 0; c < 640; c++) begin
      vga_rdn = 0; vga_addr = 13'($urandom_range(DEPTH - 1));
      @(negedge clk);
      if (cpu_ack || ram_we || ram_addr !== vga_addr) bad++;
      tick;
    end
    vga_rdn = 1;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      @(negedge clk);
      if (cpu_ack) begin lat = c; cpu_req = 0; end
      tick;
    end
    cpu_req = 0;
    ref_mem[200] = 8'h5A;
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_no_grant got=%0d bad cycles exp=0", bad); end
    checks++; if (lat < 0 || lat > 2) begin failures++; $display("FAIL stall_ack_latency got=%0d exp 0..2", lat); end
  endtask

  task automatic test_oor;
    int lat, bad_en;
    logic err;
    logic [7:0] prev;
    prev = cpu_rdata;
    cpu_xfer(1'b0, 13'd4800, 8'h00, 30, lat, err, bad_en);
    checks++; if (bad_en != 0) begin failures++; $display("FAIL oor_rd_en got=%0d enabled cycles exp=0", bad_en); end
    checks++; if (lat < 0 || err !== 1'b1) begin failures++; $display("FAIL oor_rd_err got lat=%0d err=%b exp ack/1", lat, err); end
    checks++; if (cpu_rdata !== prev) begin failures++; $display("FAIL oor_rd_hold got=%h exp=%h", cpu_rdata, prev); end
    cpu_xfer(1'b1, 13'd8191, 8'hEE, 30, lat, err, bad_en);
    checks++; if (bad_en != 0 || lat < 0 || err !== 1'b1 || cpu_rdata !== prev) begin failures++; $display("FAIL oor_wr got en=%0d lat=%0d err=%b rdata=%h exp 0/ack/1/%h", bad_en, lat, err, cpu_rdata, prev); end
  endtask

  task automatic test_clear_cpu;
    int dones = 0, acks = 0, early = 0, lat, bad_en;
    logic err;
    vga_rdn = 1; clr_start = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'd300; cpu_wdata = 8'h77;
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL clrcpu_no_grant got en=%b exp=0", ram_en); end
    tick;
    clr_start = 0;
    for (int c = 0; c < 10000 && acks == 0; c++) begin
      @(negedge clk);
      if (clr_done) dones++;
      if (cpu_ack) begin acks++; if (dones == 0) early++; cpu_req = 0; end
      tick;
    end
    cpu_req = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (clr_done) dones++;
      tick;
    end
    ref_mem[300] = 8'h77;
    checks++; if (dones != 1 || acks != 1 || early != 0) begin failures++; $display("FAIL clrcpu_order got dones=%0d acks=%0d early=%0d exp 1/1/0", dones, acks, early); end
    cpu_xfer(1'b0, 13'd300, 8'h00, 0, lat, err, bad_en);
    checks++; if (lat < 0 || cpu_rdata !== 8'h77) begin failures++; $display("FAIL clrcpu_data got lat=%0d rdata=%h exp ack/77", lat, cpu_rdata); end
    cpu_xfer(1'b0, 13'd4799, 8'h00, 0, lat, err, bad_en);
    checks++; if (lat < 0 || cpu_rdata !== ref_mem[4799]) begin failures++; $display("FAIL clrcpu_last got lat=%0d rdata=%h exp ack/%h", lat, cpu_rdata, ref_mem[4799]); end
  endtask

  task automatic test_reset_mid_clear;
    int writes = 0, dones = 0, stray = 0, bad = 0;
    logic [12:0] exp_a = 0;
    vga_rdn = 1; clr_start = 1;
    tick;
    clr_start = 0;
    for (int c = 0; c < 3000 && writes < 2000; c++) begin
      @(negedge clk);
      if (ram_en && ram_we) writes++;
      tick;
    end
    rstn = 0;
    #1;
    checks++; if ({clr_busy, clr_done, cpu_ack, cpu_err, ram_en} !== 5'b0 || cpu_rdata !== 8'h00) begin failures++; $display("FAIL rst_mid_outputs got busy/done/ack/err/en=%b rdata=%h exp 00000/00", {clr_busy, clr_done, cpu_ack, cpu_err, ram_en}, cpu_rdata); end
    tick; tick;
    rstn = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (clr_done || clr_busy || (ram_en && ram_we)) stray++;
      tick;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d events exp=0", stray); end
    clr_start = 1;
    tick;
    clr_start = 0; writes = 0;
    for (int c = 0; c < 6000 && dones == 0; c++) begin
      @(negedge clk);
      if (ram_en && ram_we) begin
        if (ram_addr !== exp_a) bad++;
        exp_a++; writes++;
      end
      if (clr_done) dones++;
      tick;
    end
    checks++; if (bad != 0 || writes != DEPTH || dones != 1) begin failures++; $display("FAIL rst_restart got bad=%0d writes=%0d dones=%0d exp 0/%0d/1", bad, writes, dones, DEPTH); end
  endtask

  initial begin
    rstn = 0; vga_rdn = 1; vga_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; clr_start = 0;
    test_reset;
    test_write_read;
    test_clear;
    test_random;
    test_vga_stall;
    test_oor;
    test_clear_cpu;
    test_reset_mid_clear;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character RAM word width.
REQ-002 SHALL have parameter DEPTH, default 4800, number of valid RAM words (80x60 cells).
REQ-003 SHALL have parameter CLR_VAL, default 8'h20, word written by the clear sweep.
REQ-004 SHALL have port clk  input  1  system clock (25 MHz pixel clock); the block uses one clock.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port vga_rdn  input  1  VGA read request, active-low, from the VGA timing controller.
REQ-007 SHALL have port vga_addr  input  13  VGA character address.
REQ-008 SHALL have port vga_q  output  DATA_W  VGA read data, equal to ram_q.
REQ-009 SHALL have port cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-010 SHALL have port cpu_we  input  1  CPU access type: 1 write, 0 read.
REQ-011 SHALL have port cpu_addr  input  13  CPU address.
REQ-012 SHALL have port cpu_wdata  input  DATA_W  CPU write data.
REQ-013 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port cpu_err  output  1  qualifies cpu_ack: address >= DEPTH.
REQ-015 SHALL have port cpu_rdata  output  DATA_W  CPU read data.
REQ-016 SHALL have port clr_start  input  1  clear-screen request pulse.
REQ-017 SHALL have port clr_busy  output  1  clear sweep in progress.
REQ-018 SHALL have port clr_done  output  1  one-cycle pulse after the last clear write.
REQ-019 SHALL have RAM port outputs ram_en (1), ram_we (1), ram_addr (13) and ram_wdata (DATA_W), plus input ram_q (DATA_W) from a synchronous RAM with 1-cycle read latency.

Function
REQ-020 SHALL drive the RAM port combinationally each cycle, using priority VGA > clear sweep > CPU.
REQ-021 SHALL, when vga_rdn=0, drive ram_en=1, ram_we=0 and ram_addr=vga_addr; vga_q is valid one cycle later.
REQ-022 SHALL implement FSM states IDLE, CLEAR and ACK; the FSM resets to IDLE.
REQ-023 SHALL, in IDLE with cpu_req=1, vga_rdn=1 and no clear pending, grant the CPU: drive ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr and ram_wdata=cpu_wdata, then go to ACK.
REQ-024 SHALL, for a CPU request with cpu_addr >= DEPTH, keep ram_en=0 and still go to ACK with the error flag set.
REQ-025 SHALL, in ACK, assert cpu_ack for exactly one cycle, set cpu_err for an out-of-range request, and return to IDLE; the CPU is never granted in ACK.
REQ-026 SHALL, in ACK for an in-range read, load cpu_rdata from ram_q and hold it until the next in-range read ack.
REQ-027 SHALL leave cpu_rdata unchanged on writes and on error acks.
REQ-028 SHALL, on clr_start=1 in IDLE or ACK, set a clear-pending flag; in IDLE, pending has priority over cpu_req, and clr_start in IDLE causes entry to CLEAR in the same cycle without granting the CPU.
REQ-029 SHALL, in CLEAR, write CLR_VAL at clr_cnt on every cycle with vga_rdn=1, incrementing clr_cnt only on granted cycles and holding it on VGA cycles.
REQ-030 SHALL, after the write at clr_cnt=DEPTH-1, wrap clr_cnt to 0, go to IDLE and pulse clr_done for one cycle.
REQ-031 SHALL hold clr_busy=1 in CLEAR and while clear is pending.
REQ-032 SHALL ignore clr_start while in CLEAR.
REQ-033 SHALL stall cpu_req during CLEAR (no ack) and service it after the return to IDLE.
REQ-034 SHALL drive ram_en=0 when no requester is granted; ram_wdata and ram_addr are don't-care then.

Reset
REQ-035 SHALL, on rstn=0, asynchronously force state=IDLE, clr_cnt=0, pending=0, cpu_ack=0, cpu_err=0, cpu_rdata=0, clr_busy=0 and clr_done=0.
REQ-036 SHALL have no RAM write occur while rstn=0 (ram_en=0 unless vga_rdn=0, read only).
REQ-037 SHALL, on reset mid-CLEAR or mid-ACK, abandon the sweep or transaction without an ack or done pulse.

Verification
REQ-038 SHALL verify: vga_rdn=1, CPU write addr 100, data 8'h41 -> ram_we=1 in grant cycle, cpu_ack next cycle, cpu_err=0; a following read of addr 100 returns cpu_rdata=8'h41.
REQ-039 SHALL verify: CPU req held while vga_rdn=0 for 640 cycles -> no grant until vga_rdn=1, then ack within 2 cycles.
REQ-040 SHALL verify: CPU read addr 4800 -> ram_en stays 0, cpu_ack=1 with cpu_err=1, cpu_rdata unchanged.
REQ-041 SHALL verify: clr_start with VGA timing running -> exactly 4800 writes of 8'h20 to addresses 0..4799, one clr_done pulse, clr_busy low afterwards.
REQ-042 SHALL verify: clr_start and cpu_req in the same IDLE cycle -> clear completes first, then the CPU is acked once.
REQ-043 SHALL verify: rstn asserted at clr_cnt=2000 -> outputs at reset values immediately, no clr_done, and a new clr_start restarts at address 0.
